// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the program RAM loader.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'h55;
  // A HI byte may only carry bits [11:8] of the word in its low nibble.
  localparam logic [7:0] HI_NIB_MASK = 8'hF0;

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-gap watchdog. The counter holds the number of cycles elapsed since the
// last byte. expired flags the edge on which that count reaches TIMEOUT_CYCLES.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte restarts the count at 1, because the next cycle is the first idle
  // cycle. Outside a frame the count is parked at 0. It saturates, so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = CW'(1);
    else if (!enable)
      cnt_d = '0;
    else if (cnt_q < CW'(TIMEOUT_CYCLES))
      cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && !clear && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_program_loader.sv
// Framed byte stream -> 12-bit program RAM writer. Holds the CPU halted until
// a frame with a good checksum has been fully written.
module ram_program_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_write_en,
  output logic                  cpu_halt,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  // The framing packs a word into one nibble plus one byte, so the width is fixed.
  if (DATA_WIDTH != 12) begin : g_bad_width
    $error("ram_program_loader: DATA_WIDTH must be 12");
  end

  localparam int          LW        = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           wc_q, wc_d;
  logic [3:0]              nib_q, nib_d;
  logic [7:0]              xor_q, xor_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    we_q, we_d;
  logic                    halt_q, halt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    to_en, to_expired;

  assign to_en = (state_q == S_LEN) || (state_q == S_HI) ||
                 (state_q == S_LO)  || (state_q == S_CHK);

  loader_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (to_en),
    .expired (to_expired)
  );

  // Next-state and datapath. A byte takes priority over a timeout in the same
  // cycle. Words already written stay written when the frame aborts.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    nib_d   = nib_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    halt_d  = halt_q;
    done_d  = done_q;
    err_d   = err_q;
    if (rx_valid) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_data == HEADER_BYTE) begin
            state_d = S_LEN;
            xor_d   = '0;
            wc_d    = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            halt_d  = 1'b1;
          end
        end
        S_LEN: begin
          xor_d = xor_q ^ rx_data;
          if ({24'd0, rx_data} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (rx_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            len_d   = LW'(rx_data);
            state_d = S_HI;
          end
        end
        S_HI: begin
          xor_d = xor_q ^ rx_data;
          if ((rx_data & HI_NIB_MASK) != 8'd0) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            nib_d   = rx_data[3:0];
            state_d = S_LO;
          end
        end
        S_LO: begin
          xor_d   = xor_q ^ rx_data;
          we_d    = 1'b1;
          addr_d  = wc_q[ADDR_WIDTH-1:0];
          din_d   = {nib_q, rx_data};
          wc_d    = wc_q + LW'(1);
          state_d = (wc_q + LW'(1) == len_q) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (rx_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (to_expired) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wc_q    <= '0;
      nib_q   <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      halt_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      nib_q   <= nib_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_din      = din_q;
  assign mem_write_en = we_q;
  assign cpu_halt     = halt_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: directed frames followed by random frames,
// all checked against a frame-level reference model.
module tb_ram_program_loader;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_write_en;
  logic          cpu_halt;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  ram_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_write_en(mem_write_en),
    .cpu_halt(cpu_halt), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int idx; } ew_t;

  wr_t obs[$];
  int  strobe[$];
  int  n_chk = 0;
  int  n_fail = 0;

  always @(negedge clk) if (mem_write_en === 1'b1) obs.push_back('{mem_addr, mem_din, cyc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    strobe.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Frame-level model: walk the byte list using the framing rules and report
  // how many bytes the loader consumes, the expected writes, and the outcome.
  task automatic model(input logic [7:0] f[$], output int used, output ew_t ew[$],
                       output bit done, output bit err);
    logic [7:0] x;
    logic [7:0] hi, lo;
    int len;
    ew = {}; done = 0; err = 0;
    len = int'(f[1]); x = f[1]; used = 2;
    if (len > (1 << AW)) begin err = 1; return; end
    for (int i = 0; i < len; i++) begin
      hi = f[2 + 2*i];
      lo = f[3 + 2*i];
      used = 3 + 2*i;
      if (hi[7:4] != 4'h0) begin err = 1; return; end
      used = 4 + 2*i;
      ew.push_back('{i[AW-1:0], {hi[3:0], lo}, 3 + 2*i});
      x = x ^ hi ^ lo;
    end
    used = used + 1;
    if (f[used-1] == x) done = 1; else err = 1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input int gap_max);
    int  used;
    ew_t ew[$];
    bit  done, err;
    int  n;
    obs = {}; strobe = {};
    model(f, used, ew, done, err);
    for (int i = 0; i < used; i++) begin
      send_byte(f[i]);
      if (i < used - 1) idle(int'($urandom_range(gap_max, 0)));
    end
    idle(3);
    check({tag, ".done"},  32'(load_done),  32'(done));
    check({tag, ".err"},   32'(load_error), 32'(err));
    check({tag, ".halt"},  32'(cpu_halt),   32'(!done));
    check({tag, ".wc"},    32'(word_count), 32'(ew.size()));
    check({tag, ".nwr"},   32'(obs.size()), 32'(ew.size()));
    n = (obs.size() < ew.size()) ? obs.size() : ew.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(obs[i].a), 32'(ew[i].a));
      check($sformatf("%s.din%0d", tag, i),  32'(obs[i].d), 32'(ew[i].d));
      check($sformatf("%s.lat%0d", tag, i),  32'(obs[i].c), 32'(strobe[ew[i].idx] + 1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".addr"}, 32'(mem_addr),     32'h0);
    check({tag, ".din"},  32'(mem_din),      32'h0);
    check({tag, ".we"},   32'(mem_write_en), 32'h0);
    check({tag, ".halt"}, 32'(cpu_halt),     32'h1);
    check({tag, ".done"}, 32'(load_done),    32'h0);
    check({tag, ".err"},  32'(load_error),   32'h0);
    check({tag, ".wc"},   32'(word_count),   32'h0);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] nominal[$];
    logic [7:0] x;
    logic [11:0] w;
    int len, kind, bad;
    int s;

    nominal = '{8'h55, 8'h02, 8'h0C, 8'h64, 8'h09, 8'h91, 8'hF2};

    // Reset state.
    idle(2);
    check_reset_vals("reset");
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Nominal load, plus the literal words it carries.
    run_frame("nominal", nominal, 0);
    if (obs.size() == 2) begin
      check("nominal.w0", 32'(obs[0].d), 32'hC64);
      check("nominal.w1", 32'(obs[1].d), 32'h991);
    end

    // Bad checksum: both words still land, then the load errors.
    f = nominal; f[6] = 8'hF3;
    run_frame("badchk", f, 1);

    // Bad HI nibble, then a good frame clears the error.
    f = '{8'h55, 8'h01, 8'h1C};
    run_frame("badnib", f, 0);
    run_frame("recover", nominal, 2);

    // Empty frame.
    f = '{8'h55, 8'h00, 8'h00};
    run_frame("empty", f, 0);

    // Timeout: error appears exactly TO cycles after the last byte.
    obs = {}; strobe = {};
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h0C);
    s = strobe[2];
    idle(1);
    while (cyc < s + TO - 1) @(negedge clk);
    check("timeout.early", 32'(load_error), 32'h0);
    @(negedge clk);
    check("timeout.cycle", 32'(cyc), 32'(s + TO));
    check("timeout.err",   32'(load_error), 32'h1);
    check("timeout.halt",  32'(cpu_halt),   32'h1);
    check("timeout.nwr",   32'(obs.size()), 32'h0);

    // Reset mid-frame, then a clean load.
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h0C); send_byte(8'h64); send_byte(8'h09);
    @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk); rst = 1'b0;
    idle(1);
    run_frame("postrst", nominal, 1);

    // Random frames with occasional corruption and random byte gaps.
    for (int t = 0; t < 25; t++) begin
      len  = int'($urandom_range(6, 0));
      kind = int'($urandom_range(9, 0));
      bad  = (len > 0) ? int'($urandom_range(len - 1, 0)) : 0;
      f = {8'h55, 8'(len)};
      x = 8'(len);
      for (int i = 0; i < len; i++) begin
        w = 12'($urandom);
        f.push_back({4'h0, w[11:8]});
        f.push_back(w[7:0]);
        if (kind == 1 && i == bad) f[2 + 2*i][7:4] = 4'($urandom_range(15, 1));
        x = x ^ f[2 + 2*i] ^ f[3 + 2*i];
      end
      if (kind == 0) x = x ^ 8'($urandom_range(255, 1));
      f.push_back(x);
      run_frame($sformatf("rand%0d", t), f, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
